// File: rtl/if_fetch_stage.sv
// rtl/if_fetch_stage.sv - PC register, imem handshake and IF/ID register for the fetch stage.
// Optional IF_PERF_CNT_EN adds fetch/wait performance counters on perf_fetch/perf_wait.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] pc,
  input  logic [31:0] pc_next,
  input  logic        id_flush,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] id_pc,
  output logic [31:0] id_inst,
  output logic        id_valid,
  output logic        if_wait,
  output logic [31:0] perf_fetch,
  output logic [31:0] perf_wait
);

  typedef enum logic [1:0] {
    ST_FETCH   = 2'd0,
    ST_HOLD    = 2'd1,
    ST_DISCARD = 2'd2
  } state_e;

  localparam logic [31:0] PC_MASK  = 32'hFFFF_FFFC;
  localparam logic [31:0] PC_RESET = RESET_PC & PC_MASK;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic [31:0] id_inst_q, id_inst_d;
  logic        id_valid_q, id_valid_d;
  logic [31:0] buf_pc_q, buf_pc_d;
  logic [31:0] buf_inst_q, buf_inst_d;
  logic [31:0] redir_q, redir_d;

  logic [31:0] pc_next_al;
  logic        accept;

  assign pc_next_al = pc_next & PC_MASK;

  // Request is gated by reset so nothing is issued until the first cycle after release.
  assign imem_req  = rst && (state_q != ST_HOLD);
  assign imem_addr = pc_q;
  assign accept    = imem_req && imem_ready;
  assign if_wait   = imem_req && !imem_ready;

  assign pc       = pc_q;
  assign id_pc    = id_pc_q;
  assign id_inst  = id_inst_q;
  assign id_valid = id_valid_q;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    id_pc_d    = id_pc_q;
    id_inst_d  = id_inst_q;
    id_valid_d = id_valid_q;
    buf_pc_d   = buf_pc_q;
    buf_inst_d = buf_inst_q;
    redir_d    = redir_q;

    unique case (state_q)
      ST_FETCH: begin
        if (accept) begin
          if (id_flush) begin
            id_pc_d    = 32'h0;
            id_inst_d  = NOP_INST;
            id_valid_d = 1'b0;
            pc_d       = pc_next_al;
          end else if (stall) begin
            buf_pc_d   = pc_q;
            buf_inst_d = imem_rdata;
            state_d    = ST_HOLD;
          end else begin
            id_pc_d    = pc_q;
            id_inst_d  = imem_rdata;
            id_valid_d = 1'b1;
            pc_d       = pc_next_al;
          end
        end else if (id_flush) begin
          // Address must stay put until the outstanding fetch returns; remember the target.
          id_pc_d    = 32'h0;
          id_inst_d  = NOP_INST;
          id_valid_d = 1'b0;
          redir_d    = pc_next_al;
          state_d    = ST_DISCARD;
        end else if (!stall) begin
          id_pc_d    = 32'h0;
          id_inst_d  = NOP_INST;
          id_valid_d = 1'b0;
        end
      end

      ST_HOLD: begin
        if (id_flush) begin
          id_pc_d    = 32'h0;
          id_inst_d  = NOP_INST;
          id_valid_d = 1'b0;
          pc_d       = pc_next_al;
          state_d    = ST_FETCH;
        end else if (!stall) begin
          id_pc_d    = buf_pc_q;
          id_inst_d  = buf_inst_q;
          id_valid_d = 1'b1;
          pc_d       = pc_next_al;
          state_d    = ST_FETCH;
        end
      end

      ST_DISCARD: begin
        if (id_flush) begin
          redir_d = pc_next_al;
        end
        if (id_flush || !stall) begin
          id_pc_d    = 32'h0;
          id_inst_d  = NOP_INST;
          id_valid_d = 1'b0;
        end
        if (accept) begin
          // A flush landing on the returning cycle is the newest redirect.
          pc_d    = id_flush ? pc_next_al : redir_q;
          state_d = ST_FETCH;
        end
      end

      default: begin
        state_d = ST_FETCH;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_FETCH;
      pc_q       <= PC_RESET;
      id_pc_q    <= 32'h0;
      id_inst_q  <= NOP_INST;
      id_valid_q <= 1'b0;
      buf_pc_q   <= 32'h0;
      buf_inst_q <= 32'h0;
      redir_q    <= 32'h0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      id_pc_q    <= id_pc_d;
      id_inst_q  <= id_inst_d;
      id_valid_q <= id_valid_d;
      buf_pc_q   <= buf_pc_d;
      buf_inst_q <= buf_inst_d;
      redir_q    <= redir_d;
    end
  end

`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetch_q, perf_fetch_d;
  logic [31:0] perf_wait_q, perf_wait_d;
  logic        fetch_hit;

  // Only words that land in IF/ID or the hold buffer count as fetched.
  assign fetch_hit = (state_q == ST_FETCH) && accept && !id_flush;

  always_comb begin
    perf_fetch_d = perf_fetch_q;
    perf_wait_d  = perf_wait_q;
    if (fetch_hit) begin
      perf_fetch_d = perf_fetch_q + 32'd1;
    end
    if (if_wait) begin
      perf_wait_d = perf_wait_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_fetch_q <= 32'h0;
      perf_wait_q  <= 32'h0;
    end else begin
      perf_fetch_q <= perf_fetch_d;
      perf_wait_q  <= perf_wait_d;
    end
  end

  assign perf_fetch = perf_fetch_q;
  assign perf_wait  = perf_wait_q;
`else
  assign perf_fetch = 32'h0;
  assign perf_wait  = 32'h0;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// tb/tb_if_fetch_stage.sv - directed self-checking bench for if_fetch_stage.
module tb_if_fetch_stage;

  logic        clk;
  logic        rst;
  logic [31:0] pc;
  logic [31:0] pc_next;
  logic        id_flush;
  logic        stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic        id_valid;
  logic        if_wait;
  logic [31:0] perf_fetch;
  logic [31:0] perf_wait;

  logic        use_tgt;
  logic [31:0] tgt;
  logic        use_word;
  logic [31:0] word;

  int checks;
  int errors;

  if_fetch_stage dut (
    .clk        (clk),
    .rst        (rst),
    .pc         (pc),
    .pc_next    (pc_next),
    .id_flush   (id_flush),
    .stall      (stall),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_rdata (imem_rdata),
    .id_pc      (id_pc),
    .id_inst    (id_inst),
    .id_valid   (id_valid),
    .if_wait    (if_wait),
    .perf_fetch (perf_fetch),
    .perf_wait  (perf_wait)
  );

  // Branch control stand-in: sequential unless a target is forced; memory returns a tagged word.
  assign pc_next    = use_tgt ? tgt : pc + 32'd4;
  assign imem_rdata = use_word ? word : {8'hA5, imem_addr[23:0]};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    rst        = 1'b0;
    id_flush   = 1'b0;
    stall      = 1'b0;
    imem_ready = 1'b1;
    use_tgt    = 1'b0;
    tgt        = 32'h0;
    use_word   = 1'b0;
    word       = 32'h0;

    tick();
    tick();
    check("rst_pc", pc, 32'h0);
    check("rst_req", {31'b0, imem_req}, 32'h0);
    check("rst_valid", {31'b0, id_valid}, 32'h0);
    check("rst_inst", id_inst, 32'h0);
    check("rst_idpc", id_pc, 32'h0);
    check("rst_perf_f", perf_fetch, 32'h0);

    // Reset release and zero-wait streaming
    rst = 1'b1;
    #1;
    check("c1_req", {31'b0, imem_req}, 32'h1);
    check("c1_addr", imem_addr, 32'h0);
    check("c1_valid", {31'b0, id_valid}, 32'h0);
    tick();
    check("c2_addr", imem_addr, 32'h4);
    check("c2_valid", {31'b0, id_valid}, 32'h1);
    check("c2_idpc", id_pc, 32'h0);
    check("c2_inst", id_inst, 32'hA500_0000);
    tick();
    check("c3_addr", imem_addr, 32'h8);
    check("c3_idpc", id_pc, 32'h4);
    tick();
    tick();
    check("c5_addr", imem_addr, 32'h10);

    // Three wait cycles at 0x10
    imem_ready = 1'b0;
    #1;
    check("w1_wait", {31'b0, if_wait}, 32'h1);
    for (int i = 0; i < 2; i++) begin
      tick();
      check("w_addr", imem_addr, 32'h10);
      check("w_wait", {31'b0, if_wait}, 32'h1);
      check("w_valid", {31'b0, id_valid}, 32'h0);
    end
    tick();
    imem_ready = 1'b1;
    #1;
    check("w4_wait", {31'b0, if_wait}, 32'h0);
    check("w4_valid", {31'b0, id_valid}, 32'h0);
    tick();
    check("w5_idpc", id_pc, 32'h10);
    check("w5_inst", id_inst, 32'hA500_0010);
    check("w5_addr", imem_addr, 32'h14);

    // Stall on an accept at 0x20
    tick();
    tick();
    tick();
    check("s0_addr", imem_addr, 32'h20);
    stall    = 1'b1;
    use_word = 1'b1;
    word     = 32'h8C01_0004;
    #1;
    check("s0_idpc", id_pc, 32'h1C);
    tick();
    use_word = 1'b0;
    #1;
    check("s1_req", {31'b0, imem_req}, 32'h0);
    check("s1_idpc", id_pc, 32'h1C);
    check("s1_pc", pc, 32'h20);
    tick();
    stall = 1'b0;
    #1;
    check("s2_req", {31'b0, imem_req}, 32'h0);
    check("s2_idpc", id_pc, 32'h1C);
    tick();
    check("s3_idpc", id_pc, 32'h20);
    check("s3_inst", id_inst, 32'h8C01_0004);
    check("s3_valid", {31'b0, id_valid}, 32'h1);
    check("s3_addr", imem_addr, 32'h24);

    // Flush while the fetch at 0x24 is outstanding
    imem_ready = 1'b0;
    id_flush   = 1'b1;
    use_tgt    = 1'b1;
    tgt        = 32'h100;
    tick();
    id_flush = 1'b0;
    use_tgt  = 1'b0;
    #1;
    check("f1_addr", imem_addr, 32'h24);
    check("f1_valid", {31'b0, id_valid}, 32'h0);
    check("f1_req", {31'b0, imem_req}, 32'h1);
    tick();
    imem_ready = 1'b1;
    #1;
    check("f2_addr", imem_addr, 32'h24);
    check("f2_valid", {31'b0, id_valid}, 32'h0);
    tick();
    check("f3_addr", imem_addr, 32'h100);
    check("f3_valid", {31'b0, id_valid}, 32'h0);
    tick();
    check("f4_idpc", id_pc, 32'h100);
    check("f4_addr", imem_addr, 32'h104);

    // Flush and stall together on an accept; target low bits must be dropped
    id_flush = 1'b1;
    stall    = 1'b1;
    use_tgt  = 1'b1;
    tgt      = 32'h203;
    tick();
    id_flush = 1'b0;
    stall    = 1'b0;
    use_tgt  = 1'b0;
    #1;
    check("fs_addr", imem_addr, 32'h200);
    check("fs_req", {31'b0, imem_req}, 32'h1);
    check("fs_valid", {31'b0, id_valid}, 32'h0);
    check("fs_idpc", id_pc, 32'h0);
    tick();
    check("fs2_idpc", id_pc, 32'h200);

    // Second flush while discarding overrides the first target
    imem_ready = 1'b0;
    id_flush   = 1'b1;
    use_tgt    = 1'b1;
    tgt        = 32'h300;
    tick();
    tgt = 32'h400;
    #1;
    check("d1_addr", imem_addr, 32'h204);
    tick();
    id_flush   = 1'b0;
    use_tgt    = 1'b0;
    imem_ready = 1'b1;
    tick();
    check("d3_addr", imem_addr, 32'h400);
    check("d3_valid", {31'b0, id_valid}, 32'h0);

    // Asynchronous reset mid-cycle, then counter sequence
    #2;
    rst = 1'b0;
    #1;
    check("ar_pc", pc, 32'h0);
    check("ar_req", {31'b0, imem_req}, 32'h0);
    tick();
    rst = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    imem_ready = 1'b0;
    tick();
    tick();
    tick();
    imem_ready = 1'b1;
    tick();
`ifdef IF_PERF_CNT_EN
    check("perf_fetch", perf_fetch, 32'd6);
    check("perf_wait", perf_wait, 32'd3);
`else
    check("perf_fetch", perf_fetch, 32'd0);
    check("perf_wait", perf_wait, 32'd0);
`endif
    check("pf_idpc", id_pc, 32'h14);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch stage directly upstream of the branch controller.
- Owns the PC register, drives a variable-latency instruction-memory request/ready handshake, and holds the IF/ID pipeline register.
- Feeds the current pc to branch control and consumes its pcNext/id_flush results.
- Handles hazard-unit stalls and branch flushes, including flushes that arrive while a fetch is still outstanding.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded at reset.
- NOP_INST, 32'h0000_0000, instruction word placed in IF/ID for bubbles.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- pc  output  32  current fetch PC, sent to branch control.
- pc_next  input  32  next PC from branch control; bits [1:0] ignored (treated as 0).
- id_flush  input  1  kill the wrong-path instruction and redirect to pc_next.
- stall  input  1  hazard unit holds the ID stage.
- imem_req  output  1  fetch request valid.
- imem_addr  output  32  fetch address; always equals pc.
- imem_ready  input  1  memory returns data this cycle.
- imem_rdata  input  32  instruction word, valid when imem_req and imem_ready are both high.
- id_pc  output  32  IF/ID PC.
- id_inst  output  32  IF/ID instruction.
- id_valid  output  1  IF/ID holds a real instruction.
- if_wait  output  1  fetch outstanding and not yet returned (imem_req and not imem_ready).
- perf_fetch  output  32  fetched-instruction count (optional feature).
- perf_wait  output  32  memory wait-cycle count (optional feature).

Behaviour:
Reset (rst low, asynchronous):
- pc = RESET_PC.
- id_pc = 0, id_inst = NOP_INST, id_valid = 0.
- Internal buffer = 0, redirect register = 0.
- State = FETCH.
- imem_req is forced to 0 while rst is low. The first request is issued in the first cycle after rst deasserts.

PC alignment:
- pc[1:0] is always 00.

FSM states: FETCH, HOLD, DISCARD.
- imem_req = 1 in FETCH and in DISCARD; 0 in HOLD.
- imem_addr must not change while imem_req is high and imem_ready is low.

"Accept" means imem_req and imem_ready are both high on a cycle. Priority per cycle is flush > stall > normal.

FETCH:
- Accept, id_flush=1:
  - IF/ID loads bubble (id_valid=0, id_inst=NOP_INST, id_pc=0).
  - Fetched word dropped.
  - pc <= pc_next; stay FETCH.
- Accept, stall=1:
  - Word and pc captured in buffer; IF/ID holds.
  - pc unchanged; go to HOLD.
- Accept, otherwise:
  - IF/ID <= {pc, imem_rdata, valid=1}.
  - pc <= pc_next; stay FETCH.
  - Zero-wait memory therefore gives 1 instruction/cycle.
- No accept, id_flush=1:
  - IF/ID loads bubble.
  - redirect register <= pc_next; go to DISCARD. The address is held because of the handshake rule.
- No accept, stall=1: IF/ID holds.
- No accept, otherwise: IF/ID loads bubble.

HOLD:
- id_flush=1:
  - Buffer dropped; IF/ID loads bubble.
  - pc <= pc_next; go to FETCH.
- stall=1: hold everything.
- Otherwise:
  - IF/ID <= {buffered pc, buffered word, valid=1}.
  - pc <= pc_next; go to FETCH.

DISCARD:
- Keep the request until imem_ready.
- On accept: drop the data, pc <= redirect register, go to FETCH.
- A further id_flush while in DISCARD overwrites the redirect register with pc_next.
- IF/ID loads bubble unless stall=1, in which case it holds.

pc_next sampling:
- pc_next is sampled only on the edges listed above. Branch control depends on ID contents, which are stable while stall is asserted.

Reset mid-operation:
- Returns to the reset state immediately.
- Any outstanding fetch is abandoned; memory must tolerate the request being dropped.

Optional Feature:
IF_PERF_CNT_EN
- Defined:
  - perf_fetch increments on every accept in FETCH that loads IF/ID or the buffer. Flush-dropped and DISCARD words are not counted.
  - perf_wait increments on every cycle with if_wait=1.
  - Both counters are 32-bit, wrap from FFFF_FFFF to 0, and reset to 0.
- Undefined:
  - Both ports are constant 0 and no counter flops exist.

Test Plan:
1. Reset release with RESET_PC=0, imem_ready=1 constantly, pc_next=pc+4 -> imem_addr 0,4,8 on consecutive cycles; id_valid=1 from the 2nd cycle; id_pc trails imem_addr by one cycle.
2. imem_ready low for 3 cycles at pc=0x10 -> imem_addr holds 0x10; if_wait=1 for 3 cycles; id_valid=0 for those cycles; one instruction lands with id_pc=0x10.
3. stall=1 for 2 cycles on an accept at pc=0x20, word 0x8C010004 -> imem_req=0 during HOLD; IF/ID unchanged; on release id_inst=0x8C010004 and id_pc=0x20; pc advances to pc_next.
4. id_flush=1 with pc_next=0x100 while a fetch at 0x24 is outstanding, ready 2 cycles later -> addr stays 0x24; data dropped; next imem_addr=0x100; id_valid=0 throughout.
5. id_flush and stall together on an accept -> bubble loaded, pc=pc_next, state FETCH (flush wins).
6. With IF_PERF_CNT_EN: 5 zero-wait fetches plus one 3-cycle wait -> perf_fetch=6, perf_wait=3. Without the macro -> both read 0.
